// File: rtl/disp_pkg.sv
// Shared display-path types and helpers for the binary-to-BCD front end.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_nibble_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Smallest digit count d with 10^d > 2^bin_w.
    function automatic int min_digits(input int bin_w);
        logic [127:0] limit;
        logic [127:0] pow10;
        int           d;
        limit = 128'd1 << bin_w;
        pow10 = 128'd1;
        d     = 0;
        while (pow10 <= limit) begin
            pow10 = pow10 * 128'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import disp_pkg::*;
(
    input  bcd_nibble_t nibble,
    output bcd_nibble_t adj
);

    assign adj = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blank mask.
// Optional build macro SIGNED_INPUT_EN: treat bin_in as two's complement and report the sign on neg.
module bin_to_bcd_seq
    import disp_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  neg
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] BLANK_ZERO = {{(DIGITS-1){1'b1}}, 1'b0};

    generate
        if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
            $fatal(1, "bin_to_bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
        end
    endgenerate

    state_t                 state;
    logic [BIN_W-1:0]       shreg;
    logic [4*DIGITS-1:0]    scratch;
    logic [4*DIGITS-1:0]    scratch_adj;
    logic [CNT_W-1:0]       cnt;
    logic                   neg_pend;
    logic                   sign_in;
    logic [BIN_W-1:0]       magnitude;
    logic [DIGITS-1:0]      blank_next;
    logic                   zero_above;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .nibble (scratch[4*g +: 4]),
                .adj    (scratch_adj[4*g +: 4])
            );
        end
    endgenerate

`ifdef SIGNED_INPUT_EN
    // Negating in BIN_W bits maps -2^(BIN_W-1) onto 2^(BIN_W-1), which still fits unsigned.
    assign sign_in   = bin_in[BIN_W-1];
    assign magnitude = sign_in ? (~bin_in) + BIN_W'(1) : bin_in;
`else
    assign sign_in   = 1'b0;
    assign magnitude = bin_in;
`endif

    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (scratch[4*i +: 4] == 4'd0);
            blank_next[i] = zero_above;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            neg_pend <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            blank    <= BLANK_ZERO;
            neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= magnitude;
                        scratch  <= '0;
                        cnt      <= '0;
                        neg_pend <= sign_in && (magnitude != '0);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[4*DIGITS-2:0], shreg[BIN_W-1]};
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_out <= scratch;
                    blank   <= blank_next;
                    neg     <= neg_pend;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
